// File: rtl/tune_trigger_pkg.sv
// Shared definitions for the tune trigger and the tune player.
// Contents:
//   tune_state_t - trigger FSM states (IDLE, FIRE, PLAY, GAP)
//   TUNE_LEN     - full tune length in clocks (2^26), also used by the
//                  tune player's duration table
//   INC_FAST     - timer step per clock when FAST_SIM is enabled
//   INC_SLOW     - timer step per clock in real-time operation
package tune_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } tune_state_t;

    localparam logic [26:0] TUNE_LEN = 27'h4000000;
    localparam logic [26:0] INC_FAST = 27'd16;
    localparam logic [26:0] INC_SLOW = 27'd1;

endpackage

// File: rtl/tune_trigger_sat_cnt.sv
// sat_cnt: 3-bit saturating up/down counter for queued tune requests.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - add one request
//   dec       - remove one request (a tune is being started)
//   load_one  - force the count to 1; overrides inc and dec
//   clr_ovfl  - clear the sticky overflow flag
//   cnt       - current count
//   ovfl      - sticky: an increment was dropped at saturation
module sat_cnt #(
    parameter int MAX = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load_one,
    input  logic       clr_ovfl,
    output logic [2:0] cnt,
    output logic       ovfl
);

    localparam logic [2:0] MAX_V = 3'(MAX);

    logic [2:0] cnt_reg;
    logic       ovfl_reg;
    logic       drop;

    // An increment with no matching decrement at the ceiling is lost.
    assign drop = inc && !dec && !load_one && (cnt_reg == MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= 3'd0;
            ovfl_reg <= 1'b0;
        end else begin
            if (load_one) begin
                cnt_reg <= 3'd1;
            end else if (inc && !dec) begin
                if (cnt_reg != MAX_V) begin
                    cnt_reg <= cnt_reg + 3'd1;
                end
            end else if (dec && !inc) begin
                if (cnt_reg != 3'd0) begin
                    cnt_reg <= cnt_reg - 3'd1;
                end
            end

            // A new overflow in the same cycle as a clear is kept.
            if (drop) begin
                ovfl_reg <= 1'b1;
            end else if (clr_ovfl) begin
                ovfl_reg <= 1'b0;
            end
        end
    end

    assign cnt  = cnt_reg;
    assign ovfl = ovfl_reg;

endmodule

// File: rtl/tune_trigger.sv
// tune_trigger: turns move-completion events into one-cycle start pulses
// for the tune player, queueing requests while a tune sounds and spacing
// tunes with a silence gap. The tune player reports no completion, so each
// tune is timed here with a play-window counter.
// Ports:
//   clk, rst   - clock (50 MHz), asynchronous active-high reset
//   move_done  - pulse: knight finished an L-move (queues a request)
//   tour_done  - pulse: tour complete (flush to one final play, lock)
//   mute       - level: suppress starting new tunes
//   clr_lock   - pulse: clear tour lockout and overflow
//   go         - one-cycle start pulse to the tune player
//   busy       - high in FIRE, PLAY or GAP
//   pend_cnt   - number of queued requests
//   ovfl       - sticky: a request was dropped at saturation
//   locked     - tour finished, move_done ignored
module tune_trigger
    import tune_pkg::*;
#(
    parameter bit          FAST_SIM  = 1'b1,
    parameter logic [26:0] TUNE_CLKS = TUNE_LEN + 27'd16,
    parameter logic [26:0] GAP_CLKS  = 27'h0400000,
    parameter int          MAX_PEND  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_done,
    input  logic       tour_done,
    input  logic       mute,
    input  logic       clr_lock,
    output logic       go,
    output logic       busy,
    output logic [2:0] pend_cnt,
    output logic       ovfl,
    output logic       locked
);

    localparam logic [26:0] INC_AMT = FAST_SIM ? INC_FAST : INC_SLOW;

    tune_state_t state_reg;
    logic [26:0] timer_reg;
    logic [27:0] timer_next;
    logic        locked_reg;
    logic        tune_expired;
    logic        gap_expired;
    logic        req_inc;
    logic        fire_req;
    logic [2:0]  pend;

    // The window ends on the cycle whose increment reaches the limit; the
    // >= compare also absorbs the overshoot of the 16-per-clock step.
    assign timer_next   = {1'b0, timer_reg} + {1'b0, INC_AMT};
    assign tune_expired = timer_next >= {1'b0, TUNE_CLKS};
    assign gap_expired  = timer_next >= {1'b0, GAP_CLKS};

    assign req_inc  = move_done && !locked_reg;
    // Mute only gates leaving IDLE; a tune already started runs out.
    assign fire_req = (state_reg == IDLE) && (pend != 3'd0) && !mute;

    sat_cnt #(
        .MAX (MAX_PEND)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (req_inc),
        .dec      (fire_req),
        .load_one (tour_done),
        .clr_ovfl (clr_lock),
        .cnt      (pend),
        .ovfl     (ovfl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            timer_reg  <= 27'd0;
            locked_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timer_reg <= 27'd0;
                    if (fire_req) begin
                        state_reg <= FIRE;
                    end
                end
                FIRE: begin
                    timer_reg <= 27'd0;
                    state_reg <= PLAY;
                end
                PLAY: begin
                    if (tune_expired) begin
                        timer_reg <= 27'd0;
                        state_reg <= GAP;
                    end else begin
                        timer_reg <= timer_next[26:0];
                    end
                end
                GAP: begin
                    if (gap_expired) begin
                        timer_reg <= 27'd0;
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_next[26:0];
                    end
                end
                default: begin
                    timer_reg <= 27'd0;
                    state_reg <= IDLE;
                end
            endcase

            // tour_done takes priority over a simultaneous clear.
            if (tour_done) begin
                locked_reg <= 1'b1;
            end else if (clr_lock) begin
                locked_reg <= 1'b0;
            end
        end
    end

    // Decoded straight from the state flop, so free of glitches.
    assign go       = (state_reg == FIRE);
    assign busy     = (state_reg != IDLE);
    assign pend_cnt = pend;
    assign locked   = locked_reg;

endmodule

// File: tb/tb_tune_trigger.sv
module tb_tune_trigger;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_done = 1'b0;
    logic       tour_done = 1'b0;
    logic       mute = 1'b0;
    logic       clr_lock = 1'b0;
    logic       go;
    logic       busy;
    logic [2:0] pend_cnt;
    logic       ovfl;
    logic       locked;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tune_trigger #(
        .FAST_SIM  (1'b1),
        .TUNE_CLKS (27'd64),
        .GAP_CLKS  (27'd32),
        .MAX_PEND  (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .move_done (move_done),
        .tour_done (tour_done),
        .mute      (mute),
        .clr_lock  (clr_lock),
        .go        (go),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .ovfl      (ovfl),
        .locked    (locked)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_move();
        move_done = 1'b1;
        step();
        move_done = 1'b0;
    endtask

    task automatic count_go(input int n, output int gos, output int min_gap);
        int last;
        last = -1;
        gos = 0;
        min_gap = 1000;
        for (int i = 0; i < n; i++) begin
            step();
            if (go) begin
                if (last >= 0 && (i - last) < min_gap) min_gap = i - last;
                last = i;
                gos++;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || pend_cnt != 3'd0) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(busy || pend_cnt != 3'd0), 0);
    endtask

    initial begin
        int gos;
        int min_gap;

        // Reset state
        step();
        step();
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_ovfl", ovfl, 0);
        chk("rst_locked", locked, 0);
        rst = 1'b0;
        step();
        step();

        // Single move: go two clocks after the move_done edge
        pulse_move();
        chk("single_e0_go", go, 0);
        chk("single_e0_pend", pend_cnt, 1);
        step();
        chk("single_e1_go", go, 1);
        chk("single_e1_pend", pend_cnt, 0);
        step();
        chk("single_e2_go", go, 0);
        chk("single_e2_busy", busy, 1);
        for (int i = 0; i < 5; i++) step();
        chk("single_e7_busy", busy, 1);
        step();
        chk("single_e8_busy", busy, 0);

        // Three moves during one PLAY
        pulse_move();
        step();
        chk("three_fire_go", go, 1);
        move_done = 1'b1;
        step();
        step();
        step();
        move_done = 1'b0;
        chk("three_pend", pend_cnt, 3);
        chk("three_busy", busy, 1);
        count_go(40, gos, min_gap);
        chk("three_gos", gos, 3);
        chk("three_spacing_ge6", int'(min_gap >= 6), 1);
        chk("three_end_pend", pend_cnt, 0);
        chk("three_end_busy", busy, 0);

        // Saturation while muted
        mute = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pulse_move();
            step();
        end
        chk("mute_pend", pend_cnt, 7);
        chk("mute_ovfl", ovfl, 1);
        chk("mute_busy", busy, 0);
        chk("mute_go", go, 0);
        mute = 1'b0;
        count_go(80, gos, min_gap);
        chk("unmute_gos", gos, 7);
        chk("unmute_ovfl", ovfl, 1);
        wait_idle(50);
        clr_lock = 1'b1;
        step();
        clr_lock = 1'b0;
        chk("clr_ovfl", ovfl, 0);

        // Increment and FIRE decrement in the same cycle
        move_done = 1'b1;
        step();
        chk("incdec_pre_pend", pend_cnt, 1);
        step();
        move_done = 1'b0;
        chk("incdec_pend", pend_cnt, 1);
        chk("incdec_go", go, 1);
        wait_idle(50);

        // tour_done with five pending mid-PLAY
        mute = 1'b1;
        for (int i = 0; i < 5; i++) pulse_move();
        chk("tour_pre_pend", pend_cnt, 5);
        mute = 1'b0;
        step();
        chk("tour_fire_go", go, 1);
        chk("tour_fire_pend", pend_cnt, 4);
        step();
        pulse_move();
        chk("tour_play_pend", pend_cnt, 5);
        tour_done = 1'b1;
        step();
        tour_done = 1'b0;
        chk("tour_flush_pend", pend_cnt, 1);
        chk("tour_locked", locked, 1);
        chk("tour_busy", busy, 1);
        pulse_move();
        pulse_move();
        chk("tour_ignored_pend", pend_cnt, 1);
        count_go(30, gos, min_gap);
        chk("tour_gos", gos, 1);
        chk("tour_end_pend", pend_cnt, 0);
        chk("tour_end_locked", locked, 1);
        wait_idle(50);

        // tour_done beats a simultaneous clr_lock
        tour_done = 1'b1;
        clr_lock = 1'b1;
        step();
        tour_done = 1'b0;
        clr_lock = 1'b0;
        chk("tourclr_locked", locked, 1);
        chk("tourclr_pend", pend_cnt, 1);
        wait_idle(50);
        clr_lock = 1'b1;
        step();
        clr_lock = 1'b0;
        chk("unlock", locked, 0);

        // Asynchronous reset during PLAY
        pulse_move();
        step();
        step();
        tour_done = 1'b1;
        step();
        tour_done = 1'b0;
        chk("prerst_locked", locked, 1);
        chk("prerst_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_go", go, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pend", pend_cnt, 0);
        chk("arst_ovfl", ovfl, 0);
        chk("arst_locked", locked, 0);
        step();
        rst = 1'b0;
        step();
        chk("postrst_go", go, 0);
        pulse_move();
        chk("postrst_e0_go", go, 0);
        chk("postrst_e0_pend", pend_cnt, 1);
        step();
        chk("postrst_e1_go", go, 1);
        wait_idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
